// File: rtl/uart_pkg.sv
// uart_pkg: widths and entry type shared by the UART receiver, its FIFO and the consumer.
package uart_pkg;
  localparam int PAYLOAD_BITS = 8;
  typedef struct packed {
    logic                    brk;
    logic [PAYLOAD_BITS-1:0] data;
  } uart_rx_entry_t;
endpackage

// File: rtl/uart_rx_fifo_mem.sv
// uart_rx_fifo_mem: unreset register array, one write port, one asynchronous read port.
module uart_rx_fifo_mem #(
  parameter int W     = 9,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);
  logic [W-1:0] mem_q [DEPTH];
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end
  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through buffer for received UART frames with fill level,
// almost-full warning and sticky overrun.
module uart_rx_fifo #(
  parameter int PAYLOAD_BITS = uart_pkg::PAYLOAD_BITS,
  parameter int DEPTH        = 16,
  parameter int ALMOST_FULL  = 12
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       uart_rx_valid,
  input  logic [PAYLOAD_BITS-1:0]    uart_rx_data,
  input  logic                       uart_rx_break,
  input  logic                       flush,
  input  logic                       overrun_clr,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [PAYLOAD_BITS-1:0]    m_data,
  output logic                       m_break,
  output logic [$clog2(DEPTH):0]     fill_level,
  output logic                       almost_full,
  output logic                       overrun
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int W  = PAYLOAD_BITS + 1;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          af_q, af_d, ov_q, ov_d;
  logic          full, wr_en, rd_en, drop;
  logic [W-1:0]  wdata, rdata;
  assign full  = count_q == CW'(DEPTH);
  assign wr_en = uart_rx_valid && !full && !flush;
  assign drop  = uart_rx_valid && full && !flush;
  assign rd_en = m_valid && m_ready && !flush;
  // BREAK frames carry no meaningful payload, so their data is stored as zero.
  assign wdata = uart_rx_break ? {1'b1, {PAYLOAD_BITS{1'b0}}} : {1'b0, uart_rx_data};
  always_comb begin
    wr_ptr_d = flush ? '0 : wr_ptr_q + AW'(wr_en);
    rd_ptr_d = flush ? '0 : rd_ptr_q + AW'(rd_en);
    count_d  = flush ? '0 : count_q + CW'(wr_en) - CW'(rd_en);
    af_d     = count_d >= CW'(ALMOST_FULL);
    ov_d     = drop || (ov_q && !overrun_clr);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      af_q     <= 1'b0;
      ov_q     <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      af_q     <= af_d;
      ov_q     <= ov_d;
    end
  end
  uart_rx_fifo_mem #(.W(W), .DEPTH(DEPTH)) u_mem (
    .clk     (clk),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q),
    .wdata_i (wdata),
    .raddr_i (rd_ptr_q),
    .rdata_o (rdata)
  );
  // Storage is unreset, so the head is masked to zero while empty.
  assign m_valid     = count_q != '0;
  assign m_break     = m_valid ? rdata[W-1] : 1'b0;
  assign m_data      = m_valid ? rdata[PAYLOAD_BITS-1:0] : '0;
  assign fill_level  = count_q;
  assign almost_full = af_q;
  assign overrun     = ov_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed-vector bench for uart_rx_fifo with hand-computed expectations.
module tb_uart_rx_fifo;
  logic       clk = 1'b0;
  logic       reset, uart_rx_valid, uart_rx_break, flush, overrun_clr, m_ready;
  logic [7:0] uart_rx_data;
  logic       m_valid, m_break, almost_full, overrun;
  logic [7:0] m_data;
  logic [4:0] fill_level;
  int         total = 0;
  int         bad = 0;

  uart_rx_fifo dut (
    .clk           (clk),
    .reset         (reset),
    .uart_rx_valid (uart_rx_valid),
    .uart_rx_data  (uart_rx_data),
    .uart_rx_break (uart_rx_break),
    .flush         (flush),
    .overrun_clr   (overrun_clr),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_data        (m_data),
    .m_break       (m_break),
    .fill_level    (fill_level),
    .almost_full   (almost_full),
    .overrun       (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input logic b);
    uart_rx_valid = 1'b1;
    uart_rx_data  = d;
    uart_rx_break = b;
    tick();
    uart_rx_valid = 1'b0;
    uart_rx_break = 1'b0;
  endtask

  task automatic pop_exp(input string tag, input logic [7:0] d);
    chk({tag, "_valid"}, m_valid, 1);
    chk({tag, "_data"}, m_data, d);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; uart_rx_valid = 1'b0; uart_rx_break = 1'b0; uart_rx_data = '0;
    flush = 1'b0; overrun_clr = 1'b0; m_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_valid", m_valid, 0);
    chk("rst_fill", fill_level, 0);
    chk("rst_af", almost_full, 0);
    chk("rst_ov", overrun, 0);
    chk("rst_data", m_data, 0);
    chk("rst_brk", m_break, 0);

    push(8'h41, 0);
    chk("lat1_valid", m_valid, 1);
    push(8'h42, 0);
    push(8'h43, 0);
    chk("three_fill", fill_level, 3);
    chk("three_head", m_data, 8'h41);
    m_ready = 1'b1;
    chk("pop0", m_data, 8'h41);
    tick();
    chk("pop1", m_data, 8'h42);
    tick();
    chk("pop2", m_data, 8'h43);
    chk("pop2_valid", m_valid, 1);
    tick();
    chk("drained_valid", m_valid, 0);
    m_ready = 1'b0;

    push(8'hFF, 1);
    chk("brk_flag", m_break, 1);
    pop_exp("brk", 8'h00);
    chk("brk_empty", m_valid, 0);

    for (int i = 0; i < 16; i++) push(8'(i), 0);
    chk("full_fill", fill_level, 16);
    chk("full_af", almost_full, 1);
    chk("full_ov0", overrun, 0);
    push(8'h55, 0);
    chk("drop_fill", fill_level, 16);
    chk("drop_ov", overrun, 1);
    uart_rx_valid = 1'b1; uart_rx_data = 8'h66; m_ready = 1'b1;
    tick();
    uart_rx_valid = 1'b0; m_ready = 1'b0;
    chk("rdwr_full_fill", fill_level, 15);
    chk("rdwr_full_ov", overrun, 1);
    push(8'h77, 0);
    chk("refill", fill_level, 16);
    overrun_clr = 1'b1;
    push(8'h88, 0);
    chk("clr_vs_set_ov", overrun, 1);
    chk("clr_vs_set_fill", fill_level, 16);
    tick();
    overrun_clr = 1'b0;
    chk("clr_ov", overrun, 0);
    for (int i = 1; i < 16; i++) pop_exp($sformatf("drain%0d", i), 8'(i));
    pop_exp("drain77", 8'h77);
    chk("drain_empty", m_valid, 0);
    chk("drain_fill", fill_level, 0);

    for (int i = 0; i < 11; i++) push(8'(8'h20 + i), 0);
    chk("af11", almost_full, 0);
    push(8'h2B, 0);
    chk("af12", almost_full, 1);
    pop_exp("af_pop", 8'h20);
    chk("af_pop_af", almost_full, 0);
    chk("af_pop_fill", fill_level, 11);
    for (int i = 0; i < 5; i++) push(8'(8'h30 + i), 0);
    push(8'h99, 0);
    chk("pre_flush_ov", overrun, 1);
    for (int i = 1; i < 12; i++) pop_exp($sformatf("to5_%0d", i), 8'(8'h20 + i));
    chk("five_fill", fill_level, 5);
    flush = 1'b1;
    push(8'hAA, 0);
    flush = 1'b0;
    chk("flush_fill", fill_level, 0);
    chk("flush_valid", m_valid, 0);
    chk("flush_ov", overrun, 1);
    push(8'h7E, 0);
    chk("post_flush_fill", fill_level, 1);
    pop_exp("post_flush", 8'h7E);
    chk("final_empty", m_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side byte buffer directly downstream of the UART receiver. Captures each single-cycle `uart_rx_valid` pulse with its data byte and BREAK flag into a synchronous first-word-fall-through FIFO. Presents entries to the consumer over a valid/ready handshake. Reports fill level, an almost-full warning and a sticky overrun flag.

## Interface
Parameters:
- `PAYLOAD_BITS`, 8: data width; matches the receiver.
- `DEPTH`, 16: entry count; power of two, ≥ 2.
- `ALMOST_FULL`, 12: `almost_full` threshold; 1 ≤ ALMOST_FULL ≤ DEPTH.

Ports:
- `clk` in 1: single system clock.
- `reset` in 1: reset, synchronous and active-high.
- `uart_rx_valid` in 1: one-cycle pulse when the receiver completes a frame.
- `uart_rx_data` in PAYLOAD_BITS: received byte; sampled only when `uart_rx_valid`=1.
- `uart_rx_break` in 1: BREAK frame flag; sampled only when `uart_rx_valid`=1.
- `flush` in 1: discards all entries.
- `overrun_clr` in 1: clears `overrun`.
- `m_valid` out 1: FIFO non-empty.
- `m_ready` in 1: consumer accepts the head entry.
- `m_data` out PAYLOAD_BITS: head entry data.
- `m_break` out 1: head entry BREAK flag.
- `fill_level` out $clog2(DEPTH)+1: current entry count, 0..DEPTH.
- `almost_full` out 1: `fill_level` ≥ ALMOST_FULL.
- `overrun` out 1: sticky; set when a frame was dropped because the FIFO was full.

## Operation
- Each entry is {brk, data}. A BREAK frame is stored as brk=1, data=0, forced to zero regardless of `uart_rx_data`.
- Write: when `uart_rx_valid`=1 and `fill_level` < DEPTH at the start of the cycle. No pass-through on full: a write while full is dropped even if a read happens in the same cycle.
- Dropped write sets `overrun`. If set and `overrun_clr` occur in the same cycle, set wins.
- Read: when `m_valid`=1 and `m_ready`=1, the head pops.
- `m_data`/`m_break` hold the head entry whenever `m_valid`=1. They are stable while `m_valid`=1 and `m_ready`=0. Their value is don't-care when `m_valid`=0.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. `fill_level` is a separate counter: +1 on write only, −1 on read only, unchanged on both.
- `flush` clears the pointers and `fill_level` and takes priority over a same-cycle write or read. The write is lost, no overrun is raised, and `overrun` itself is unaffected.
- Reset behaves like flush and also clears `overrun`. Reset mid-stream drops all contents.
- No internal FSM beyond the empty/partial/full occupancy implied by `fill_level`.

## Timing
- Reset values: `m_valid`=0, `fill_level`=0, `almost_full`=0, `overrun`=0, `m_data`=0, `m_break`=0. Storage contents are undefined.
- Write-to-visible latency is 1 cycle. A pulse at cycle N into an empty FIFO gives `m_valid`=1 at N+1.
- A pop at cycle N presents the next head at N+1. `m_valid` falls at N+1 if that pop emptied the FIFO.
- `fill_level`, `almost_full` and `overrun` are registered and reflect the events of the previous edge.
- Sustained throughput is one write and one read per cycle. The receiver pulses far less often.

## Structure
- Shared package `uart_pkg`:
  - `PAYLOAD_BITS` default.
  - Typedef `uart_rx_entry_t` {brk, data}, shared with the receiver and with the consumer.
- Sub-module `uart_rx_fifo_mem`: DEPTH × entry register array with one write port and one asynchronous read port, no reset on the array.
- The top level holds the pointers, the count, the flags and the handshake.

## Test plan
- Reset, then three pulses with data 0x41, 0x42, 0x43 and `m_ready`=0 → `fill_level`=3 and `m_data`=0x41. Then `m_ready`=1 → 0x41, 0x42, 0x43 pop on consecutive cycles, and `m_valid` falls after the third.
- BREAK pulse with `uart_rx_data`=0xFF and `uart_rx_break`=1 → entry pops as `m_break`=1, `m_data`=0x00.
- Fill 16 entries, then pulse 0x55 → `fill_level` stays 16 and `overrun`=1 next cycle. Drain → 0x55 is never seen.
- With the FIFO full, pulse in the same cycle as a pop → write dropped, `fill_level`=15, `overrun`=1. Assert `overrun_clr` together with another dropped write → `overrun` stays 1.
- Fill to 12 entries → `almost_full`=1. Pop one → `almost_full`=0.
- With 5 entries, assert `flush` together with a pulse → next cycle `fill_level`=0 and `m_valid`=0. `overrun` is unchanged. Write 0x7E → it is the next entry out.
